colide_multi_obstaculo: RTL and testbench

Parametrised successor to the per-frame collision check for the VGA moving object. It tests the object bounding box against the monitor borders and a runtime-programmable table of NUM_OBST rectangular obstacles. It produces registered per-direction blocking flags, an overlap flag and the index of the first obstacle hit. It sits between the object position register and the keyboard movement logic, and is triggered once per frame with one table entry scanned per clock.

---
 rtl/colisao_pkg.sv | 38 +++
 rtl/colide_retangulo.sv | 57 +++++
 rtl/colide_multi_obstaculo.sv | 233 +++++++++++++++++++++++
 tb/tb_colide_multi_obstaculo.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/colisao_pkg.sv
// Shared types and default constants for the multi-obstacle collision checker.
package colisao_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_FIM  = 2'd2
    } estado_t;

    // Table coordinates are stored at a fixed width wide enough for any practical monitor
    localparam int COORD_W = 16;

    typedef struct packed {
        logic               en;
        logic [COORD_W-1:0] x0;
        logic [COORD_W-1:0] y0;
        logic [COORD_W-1:0] x1;
        logic [COORD_W-1:0] y1;
    } obst_t;

    localparam int DEF_MON_MIN_X = 1;
    localparam int DEF_MON_MAX_X = 640;
    localparam int DEF_MON_MIN_Y = 1;
    localparam int DEF_MON_MAX_Y = 480;

    // Cleared (disabled) table entry
    function automatic obst_t obst_vazio();
        obst_t e;
        e.en = 1'b0;
        e.x0 = {COORD_W{1'b0}};
        e.y0 = {COORD_W{1'b0}};
        e.x1 = {COORD_W{1'b0}};
        e.y1 = {COORD_W{1'b0}};
        return e;
    endfunction

endpackage

// File: rtl/colide_retangulo.sv
// Combinational test of the object snapshot against one obstacle rectangle.
module colide_retangulo
    import colisao_pkg::*;
#(
    parameter int X_W    = 10,
    parameter int Y_W    = 9,
    parameter int SIZE_W = 7,
    parameter int MARGEM = 1
) (
    input  logic              en,
    input  logic [X_W-1:0]    x0,
    input  logic [X_W-1:0]    x1,
    input  logic [Y_W-1:0]    y0,
    input  logic [Y_W-1:0]    y1,
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    input  logic [SIZE_W-1:0] w,
    input  logic [SIZE_W-1:0] h,
    output logic              col_max_x,
    output logic              col_min_x,
    output logic              col_max_y,
    output logic              col_min_y,
    output logic              overlap
);
    localparam int XI = X_W + 2;
    localparam int YI = Y_W + 2;
    localparam logic signed [XI-1:0] UM_X = XI'(1);
    localparam logic signed [YI-1:0] UM_Y = YI'(1);
    localparam logic signed [XI-1:0] M_X  = XI'(MARGEM);
    localparam logic signed [YI-1:0] M_Y  = YI'(MARGEM);

    logic signed [XI-1:0] xs_s, rs_s, x0s_s, x1s_s;
    logic signed [YI-1:0] ys_s, bs_s, y0s_s, y1s_s;
    logic                 ovx_s, ovy_s;

    // Widened signed compare of the object box (right edge R, bottom B) against the entry
    always_comb begin
        xs_s  = $signed(XI'(x));
        rs_s  = xs_s + $signed(XI'(w));
        x0s_s = $signed(XI'(x0));
        x1s_s = $signed(XI'(x1));
        ys_s  = $signed(YI'(y));
        bs_s  = ys_s + $signed(YI'(h));
        y0s_s = $signed(YI'(y0));
        y1s_s = $signed(YI'(y1));

        ovx_s = (xs_s <= x1s_s) && ((rs_s - UM_X) >= x0s_s);
        ovy_s = (ys_s <= y1s_s) && ((bs_s - UM_Y) >= y0s_s);

        col_max_x = en && ovy_s && (rs_s <= x0s_s) && (x0s_s <= (rs_s + M_X - UM_X));
        col_min_x = en && ovy_s && ((xs_s - M_X) <= x1s_s) && (x1s_s <= (xs_s - UM_X));
        col_max_y = en && ovx_s && (bs_s <= y0s_s) && (y0s_s <= (bs_s + M_Y - UM_Y));
        col_min_y = en && ovx_s && ((ys_s - M_Y) <= y1s_s) && (y1s_s <= (ys_s - UM_Y));
        overlap   = en && ovx_s && ovy_s;
    end

endmodule

// File: rtl/colide_multi_obstaculo.sv
// Per-frame collision check of the moving object against monitor borders and an
// obstacle table, scanning one table entry per clock.
module colide_multi_obstaculo
    import colisao_pkg::*;
#(
    parameter int NUM_OBST  = 8,
    parameter int X_W       = 10,
    parameter int Y_W       = 9,
    parameter int SIZE_W    = 7,
    parameter int MON_MIN_X = DEF_MON_MIN_X,
    parameter int MON_MAX_X = DEF_MON_MAX_X,
    parameter int MON_MIN_Y = DEF_MON_MIN_Y,
    parameter int MON_MAX_Y = DEF_MON_MAX_Y,
    parameter int MARGEM    = 1,
    localparam int IW       = (NUM_OBST > 1) ? $clog2(NUM_OBST) : 1
) (
    input  logic              VGA_clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [SIZE_W-1:0] tamanho_x,
    input  logic [SIZE_W-1:0] tamanho_y,
    input  logic [X_W-1:0]    xPos,
    input  logic [Y_W-1:0]    yPos,
    input  logic              obst_we,
    input  logic [IW-1:0]     obst_idx,
    input  logic              obst_en,
    input  logic [X_W-1:0]    obst_x0,
    input  logic [X_W-1:0]    obst_x1,
    input  logic [Y_W-1:0]    obst_y0,
    input  logic [Y_W-1:0]    obst_y1,
    output logic              busy,
    output logic              done,
    output logic              colisao_max_x,
    output logic              colisao_min_x,
    output logic              colisao_max_y,
    output logic              colisao_min_y,
    output logic              sobreposicao,
    output logic              hit_any,
    output logic [IW-1:0]     hit_idx
);
    localparam int XI = X_W + 2;
    localparam int YI = Y_W + 2;
    localparam logic signed [XI-1:0] LIM_MAX_X = XI'(MON_MAX_X - MARGEM + 1);
    localparam logic signed [XI-1:0] LIM_MIN_X = XI'(MON_MIN_X + MARGEM - 1);
    localparam logic signed [YI-1:0] LIM_MAX_Y = YI'(MON_MAX_Y - MARGEM + 1);
    localparam logic signed [YI-1:0] LIM_MIN_Y = YI'(MON_MIN_Y + MARGEM - 1);
    localparam logic [IW-1:0]        IDX_ULT   = IW'(NUM_OBST - 1);

    estado_t             state_q, state_d;
    obst_t               tab_q [NUM_OBST];
    obst_t               tab_d [NUM_OBST];
    logic [IW-1:0]       idx_q, idx_d;
    logic [X_W-1:0]      x_q, x_d;
    logic [Y_W-1:0]      y_q, y_d;
    logic [SIZE_W-1:0]   w_q, w_d, h_q, h_d;
    logic [4:0]          acc_q, acc_d;      // {max_x, min_x, max_y, min_y, overlap}
    logic                acc_hit_q, acc_hit_d;
    logic [IW-1:0]       acc_idx_q, acc_idx_d;
    logic [4:0]          out_q, out_d;
    logic                hit_q, hit_d;
    logic [IW-1:0]       hidx_q, hidx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    obst_t               ent_s;
    logic [4:0]          ent_res_s;
    logic [3:0]          borda_s;
    logic signed [XI-1:0] rs_s, xs_s;
    logic signed [YI-1:0] bs_s, ys_s;

    assign ent_s = tab_q[idx_q];

    colide_retangulo #(
        .X_W    (X_W),
        .Y_W    (Y_W),
        .SIZE_W (SIZE_W),
        .MARGEM (MARGEM)
    ) u_ret (
        .en        (ent_s.en),
        .x0        (ent_s.x0[X_W-1:0]),
        .x1        (ent_s.x1[X_W-1:0]),
        .y0        (ent_s.y0[Y_W-1:0]),
        .y1        (ent_s.y1[Y_W-1:0]),
        .x         (x_q),
        .y         (y_q),
        .w         (w_q),
        .h         (h_q),
        .col_max_x (ent_res_s[4]),
        .col_min_x (ent_res_s[3]),
        .col_max_y (ent_res_s[2]),
        .col_min_y (ent_res_s[1]),
        .overlap   (ent_res_s[0])
    );

    // Border lookahead terms from the snapshot
    always_comb begin
        xs_s = $signed(XI'(x_q));
        rs_s = xs_s + $signed(XI'(w_q));
        ys_s = $signed(YI'(y_q));
        bs_s = ys_s + $signed(YI'(h_q));
        borda_s[3] = (rs_s > LIM_MAX_X);
        borda_s[2] = (xs_s < LIM_MIN_X);
        borda_s[1] = (bs_s > LIM_MAX_Y);
        borda_s[0] = (ys_s < LIM_MIN_Y);
    end

    // Table write port; out-of-range indices are dropped
    always_comb begin
        tab_d = tab_q;
        if (obst_we && (int'(obst_idx) < NUM_OBST)) begin
            tab_d[obst_idx].en = obst_en;
            tab_d[obst_idx].x0 = COORD_W'(obst_x0);
            tab_d[obst_idx].x1 = COORD_W'(obst_x1);
            tab_d[obst_idx].y0 = COORD_W'(obst_y0);
            tab_d[obst_idx].y1 = COORD_W'(obst_y1);
        end else begin
            tab_d = tab_q;
        end
    end

    // Scan controller: next state, accumulators and output loads
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        w_d       = w_q;
        h_d       = h_q;
        acc_d     = acc_q;
        acc_hit_d = acc_hit_q;
        acc_idx_d = acc_idx_q;
        out_d     = out_q;
        hit_d     = hit_q;
        hidx_d    = hidx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    x_d       = xPos;
                    y_d       = yPos;
                    w_d       = tamanho_x;
                    h_d       = tamanho_y;
                    acc_d     = 5'b00000;
                    acc_hit_d = 1'b0;
                    acc_idx_d = {IW{1'b0}};
                    idx_d     = {IW{1'b0}};
                    busy_d    = 1'b1;
                    state_d   = ST_SCAN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_SCAN: begin
                acc_d = acc_q | ent_res_s;
                // Only the first contributing entry sets the index
                if ((ent_res_s != 5'b00000) && !acc_hit_q) begin
                    acc_hit_d = 1'b1;
                    acc_idx_d = idx_q;
                end else begin
                    acc_hit_d = acc_hit_q;
                end
                if (idx_q == IDX_ULT) begin
                    state_d = ST_FIM;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_FIM: begin
                out_d   = acc_q | {borda_s, 1'b0};
                hit_d   = acc_hit_q;
                hidx_d  = acc_hit_q ? acc_idx_q : {IW{1'b0}};
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, snapshot, table and output registers
    always_ff @(posedge VGA_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= {IW{1'b0}};
            x_q       <= {X_W{1'b0}};
            y_q       <= {Y_W{1'b0}};
            w_q       <= {SIZE_W{1'b0}};
            h_q       <= {SIZE_W{1'b0}};
            acc_q     <= 5'b00000;
            acc_hit_q <= 1'b0;
            acc_idx_q <= {IW{1'b0}};
            out_q     <= 5'b00000;
            hit_q     <= 1'b0;
            hidx_q    <= {IW{1'b0}};
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NUM_OBST; i++) begin
                tab_q[i] <= obst_vazio();
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            y_q       <= y_d;
            w_q       <= w_d;
            h_q       <= h_d;
            acc_q     <= acc_d;
            acc_hit_q <= acc_hit_d;
            acc_idx_q <= acc_idx_d;
            out_q     <= out_d;
            hit_q     <= hit_d;
            hidx_q    <= hidx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            tab_q     <= tab_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign colisao_max_x = out_q[4];
    assign colisao_min_x = out_q[3];
    assign colisao_max_y = out_q[2];
    assign colisao_min_y = out_q[1];
    assign sobreposicao  = out_q[0];
    assign hit_any       = hit_q;
    assign hit_idx       = hidx_q;

endmodule

// File: tb/tb_colide_multi_obstaculo.sv
// Directed self-checking bench for colide_multi_obstaculo (NUM_OBST=4, MARGEM=1, object 20x20).
module tb_colide_multi_obstaculo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [6:0] tamanho_x = 7'd20;
    logic [6:0] tamanho_y = 7'd20;
    logic [9:0] xPos = 10'd0;
    logic [8:0] yPos = 9'd0;
    logic       obst_we = 1'b0;
    logic [1:0] obst_idx = 2'd0;
    logic       obst_en = 1'b0;
    logic [9:0] obst_x0 = 10'd0;
    logic [9:0] obst_x1 = 10'd0;
    logic [8:0] obst_y0 = 9'd0;
    logic [8:0] obst_y1 = 9'd0;
    logic       busy, done;
    logic       colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y;
    logic       sobreposicao, hit_any;
    logic [1:0] hit_idx;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    colide_multi_obstaculo #(.NUM_OBST(4)) dut (
        .VGA_clk       (clk),
        .reset_n       (reset_n),
        .start         (start),
        .tamanho_x     (tamanho_x),
        .tamanho_y     (tamanho_y),
        .xPos          (xPos),
        .yPos          (yPos),
        .obst_we       (obst_we),
        .obst_idx      (obst_idx),
        .obst_en       (obst_en),
        .obst_x0       (obst_x0),
        .obst_x1       (obst_x1),
        .obst_y0       (obst_y0),
        .obst_y1       (obst_y1),
        .busy          (busy),
        .done          (done),
        .colisao_max_x (colisao_max_x),
        .colisao_min_x (colisao_min_x),
        .colisao_max_y (colisao_max_y),
        .colisao_min_y (colisao_min_y),
        .sobreposicao  (sobreposicao),
        .hit_any       (hit_any),
        .hit_idx       (hit_idx)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] flags();
        return {27'd0, colisao_max_x, colisao_min_x, colisao_max_y, colisao_min_y, sobreposicao};
    endfunction

    task automatic write_obst(input int idx, input logic en, input int x0, input int y0,
                              input int x1, input int y1);
        @(negedge clk);
        obst_we  = 1'b1;
        obst_idx = 2'(idx);
        obst_en  = en;
        obst_x0  = 10'(x0);
        obst_y0  = 9'(y0);
        obst_x1  = 10'(x1);
        obst_y1  = 9'(y1);
        @(negedge clk);
        obst_we  = 1'b0;
    endtask

    // Wait (bounded) for done; cycle count is relative to the start cycle
    task automatic wait_done(input string tag, input int lat0);
        int lat;
        lat = lat0;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check_eq({tag, "_lat"}, lat, 6);
    endtask

    task automatic run_check(input string tag, input int x, input int y);
        @(negedge clk);
        xPos  = 10'(x);
        yPos  = 9'(y);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(tag, 1);
    endtask

    task automatic expect_res(input string tag, input logic [4:0] f, input logic ha, input int hi);
        check_eq({tag, "_flags"}, flags(), {27'd0, f});
        check_eq({tag, "_hit_any"}, {31'd0, hit_any}, {31'd0, ha});
        check_eq({tag, "_hit_idx"}, {30'd0, hit_idx}, 32'(hi));
    endtask

    initial begin
        int ndone;
        // Reset state
        repeat (3) @(negedge clk);
        expect_res("reset", 5'b00000, 1'b0, 0);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;

        // Borders, empty table (flags order: max_x min_x max_y min_y overlap)
        run_check("b620", 620, 200);  expect_res("b620", 5'b00000, 1'b0, 0);
        run_check("b621", 621, 200);  expect_res("b621", 5'b10000, 1'b0, 0);
        run_check("bx0", 0, 200);     expect_res("bx0", 5'b01000, 1'b0, 0);
        run_check("by461", 300, 461); expect_res("by461", 5'b00100, 1'b0, 0);
        run_check("by0", 300, 0);     expect_res("by0", 5'b00010, 1'b0, 0);

        // Single obstacle 2 at (300,100)-(339,139)
        write_obst(2, 1'b1, 300, 100, 339, 139);
        run_check("o_right", 280, 110); expect_res("o_right", 5'b10000, 1'b1, 2);
        run_check("o_novy", 280, 140);  expect_res("o_novy", 5'b00000, 1'b0, 0);
        run_check("o_left", 340, 110);  expect_res("o_left", 5'b01000, 1'b1, 2);
        run_check("o_ovl", 310, 110);   expect_res("o_ovl", 5'b00001, 1'b1, 2);

        // Start while busy: second pulse must be ignored
        @(negedge clk);
        xPos = 10'd310; yPos = 9'd110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        xPos = 10'd280; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        check_eq("busy_start_dones", ndone, 1);
        expect_res("busy_start", 5'b00001, 1'b1, 2);

        // Priority between entries 1 and 3
        write_obst(2, 1'b0, 300, 100, 339, 139);
        write_obst(1, 1'b1, 300, 100, 339, 139);
        write_obst(3, 1'b1, 300, 120, 310, 200);
        run_check("prio13", 280, 110);  expect_res("prio13", 5'b10000, 1'b1, 1);
        write_obst(1, 1'b0, 300, 100, 339, 139);
        run_check("prio3", 280, 110);   expect_res("prio3", 5'b10000, 1'b1, 3);
        write_obst(3, 1'b0, 300, 120, 310, 200);
        run_check("prio_none", 280, 110); expect_res("prio_none", 5'b00000, 1'b0, 0);

        // Write to entry 2 during SCAN, before the scan reaches it
        @(negedge clk);
        xPos = 10'd280; yPos = 9'd110; start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        obst_we  = 1'b1; obst_idx = 2'd2; obst_en = 1'b1;
        obst_x0  = 10'd300; obst_y0 = 9'd100; obst_x1 = 10'd339; obst_y1 = 9'd139;
        @(negedge clk);
        obst_we  = 1'b0;
        wait_done("wr_scan", 2);
        expect_res("wr_scan", 5'b10000, 1'b1, 2);

        // Reset in the middle of SCAN
        @(negedge clk);
        xPos = 10'd310; yPos = 9'd110; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        expect_res("rst_scan", 5'b00000, 1'b0, 0);
        check_eq("rst_scan_busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done === 1'b1) ndone++;
            @(negedge clk);
        end
        check_eq("rst_scan_dones", ndone, 0);
        run_check("rst_tab", 310, 110); expect_res("rst_tab", 5'b00000, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
